// File: rtl/axi_burst_memory_model.sv
// ---------------------------------------------------------------------------
// axi_burst_memory_model
//
// Behavioural AXI4 slave memory that stands in for external DRAM in
// accelerator system benches. Serves INCR and FIXED bursts (WRAP is handled
// as INCR) from a word-addressed array `mem`. Benches may preload or inspect
// `mem` hierarchically. Read and write channels are independent, and each
// channel has at most one outstanding transaction.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst_n          : synchronous reset, active HIGH (reset when 1)
//   s_axi_aw*      : write address channel (id, addr, len, size, burst, valid/ready)
//   s_axi_w*       : write data channel (data, strobe, last, valid/ready)
//   s_axi_b*       : write response channel (id, resp, valid/ready)
//   s_axi_ar*      : read address channel (id, addr, len, size, burst, valid/ready)
//   s_axi_r*       : read data channel (id, data, resp, last, valid/ready)
//
// Both responses are always OKAY. Addresses beyond the array wrap modulo the
// depth. The array is zero at time 0 and is never cleared by reset, so
// preloads made before reset survive.
// ---------------------------------------------------------------------------
module axi_burst_memory_model #(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_SIZE_MB    = 1,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_LATENCY  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,

  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int DEPTH    = MEM_SIZE_MB * 1048576 / STRB_W;
  localparam int IDX_W    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_e;

  // Backing store. The declaration initialiser zeroes it once at time 0;
  // reset deliberately leaves it alone so bench preloads survive.
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Maps a byte address to a word index. The modulo makes out-of-range
  // addresses alias back into the array instead of faulting.
  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] word;
    word = addr >> ADDR_LSB;
    return IDX_W'(word % AXI_ADDR_WIDTH'(DEPTH));
  endfunction

  // Address of the following beat. FIXED bursts hold the address; INCR and
  // WRAP both step by the beat size (WRAP boundaries are not modelled).
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    if (burst == 2'b00) begin
      return addr;
    end
    return addr + (AXI_ADDR_WIDTH'(1) << size);
  endfunction

  // ------------------------------------------------------------------
  // Write channel state
  // ------------------------------------------------------------------
  w_state_e                  w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   awid_q, awid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]                awlen_q, awlen_d;
  logic [2:0]                awsize_q, awsize_d;
  logic [1:0]                awburst_q, awburst_d;
  logic [7:0]                wbeat_q, wbeat_d;
  logic [31:0]               wlat_q, wlat_d;

  logic                      mem_we;
  logic [IDX_W-1:0]          mem_widx;

  // ------------------------------------------------------------------
  // Read channel state
  // ------------------------------------------------------------------
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   arid_q, arid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [2:0]                arsize_q, arsize_d;
  logic [1:0]                arburst_q, arburst_d;
  logic [7:0]                rbeat_q, rbeat_d;
  logic [31:0]               rlat_q, rlat_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rlast_q, rlast_d;

  logic [AXI_ADDR_WIDTH-1:0] rd_next_addr;

  assign rd_next_addr = next_addr(araddr_q, arsize_q, arburst_q);

  // Write-side next-state logic. The AW handshake captures the burst
  // description; each accepted W beat steps the address. The burst ends on
  // wlast or when the beat count reaches awlen, whichever comes first, so a
  // master that forgets wlast cannot hang the model. The optional W_WAIT
  // stage emulates write-response latency before bvalid rises.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wbeat_d   = wbeat_q;
    wlat_d    = wlat_q;

    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          awid_d    = s_axi_awid;
          awaddr_d  = s_axi_awaddr;
          awlen_d   = s_axi_awlen;
          awsize_d  = s_axi_awsize;
          awburst_d = s_axi_awburst;
          wbeat_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          wbeat_d  = wbeat_q + 8'd1;
          awaddr_d = next_addr(awaddr_q, awsize_q, awburst_q);
          if (s_axi_wlast || (wbeat_q == awlen_q)) begin
            wlat_d    = 32'd0;
            w_state_d = (WRITE_LATENCY == 0) ? W_RESP : W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wlat_q == 32'(WRITE_LATENCY - 1)) begin
          w_state_d = W_RESP;
        end else begin
          wlat_d = wlat_q + 32'd1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write-side registers. Reset drops any burst in flight and returns the
  // channel to idle with awready high.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wbeat_q   <= '0;
      wlat_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wbeat_q   <= wbeat_d;
      wlat_q    <= wlat_d;
    end
  end

  assign mem_we   = !rst_n && (w_state_q == W_DATA) && s_axi_wvalid;
  assign mem_widx = word_idx(awaddr_q);

  // Memory write port. Only the byte lanes with their strobe set are
  // updated; the remaining lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[mem_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read-side next-state logic. rdata is registered and loaded at the moment
  // a beat is first presented, so it stays frozen while the master stalls
  // with rready low. With zero latency the first word is fetched straight
  // from the incoming araddr during the AR handshake. rlast is precomputed
  // alongside the data it accompanies.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rbeat_d   = rbeat_q;
    rlat_d    = rlat_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;

    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          arid_d    = s_axi_arid;
          araddr_d  = s_axi_araddr;
          arlen_d   = s_axi_arlen;
          arsize_d  = s_axi_arsize;
          arburst_d = s_axi_arburst;
          rbeat_d   = 8'd0;
          rlat_d    = 32'd0;
          if (READ_LATENCY == 0) begin
            rdata_d   = mem[word_idx(s_axi_araddr)];
            rlast_d   = (s_axi_arlen == 8'd0);
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rlat_q == 32'(READ_LATENCY - 1)) begin
          rdata_d   = mem[word_idx(araddr_q)];
          rlast_d   = (arlen_q == 8'd0);
          r_state_d = R_DATA;
        end else begin
          rlat_d = rlat_q + 32'd1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            araddr_d = rd_next_addr;
            rbeat_d  = rbeat_q + 8'd1;
            rdata_d  = mem[word_idx(rd_next_addr)];
            rlast_d  = ((rbeat_q + 8'd1) == arlen_q);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read-side registers. Reset drops any burst in flight and clears the
  // visible read outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rbeat_q   <= '0;
      rlat_q    <= '0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rbeat_q   <= rbeat_d;
      rlat_q    <= rlat_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
    end
  end

  // Handshake outputs follow directly from the channel states.
  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = awid_q;
  assign s_axi_bresp   = 2'b00;

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = arid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_burst_memory_model.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_memory_model
//
// Directed bench for axi_burst_memory_model at default parameters. Walks a
// fixed sequence: reset values, single-beat read latency, INCR write burst,
// byte strobes, read backpressure, FIXED write, address wrap, and reset in
// the middle of a read burst.
// ---------------------------------------------------------------------------
module tb_axi_burst_memory_model;

  logic         clk;
  logic         rst_n;

  logic [3:0]   awid;
  logic [39:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;

  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  logic [3:0]   arid;
  logic [39:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;

  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int checks = 0;
  int errors = 0;

  axi_burst_memory_model dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it, so inputs are
  // driven and outputs sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue an AW handshake (the model is idle, so it completes in one edge).
  task automatic sendAw(input logic [39:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [3:0] id);
    awaddr  = addr;
    awlen   = len;
    awsize  = 3'd5;
    awburst = burst;
    awid    = id;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
  endtask

  // Issue an AR handshake.
  task automatic sendAr(input logic [39:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [3:0] id);
    araddr  = addr;
    arlen   = len;
    arsize  = 3'd5;
    arburst = burst;
    arid    = id;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  // Drive one write-data beat for one edge (wready is high throughout W_DATA).
  task automatic applyStimulus(input logic [255:0] data, input logic [31:0] strb,
                               input logic last);
    wdata  = data;
    wstrb  = strb;
    wlast  = last;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Wait (bounded) for the write response, check it, then accept it.
  task automatic finishWrite(input string tag, input logic [3:0] id);
    for (int i = 0; i < 8 && !bvalid; i++) tick();
    checkOutput({tag, "_bvalid"}, 256'(bvalid), 256'd1);
    checkOutput({tag, "_bid"}, 256'(bid), 256'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Wait (bounded) for rvalid to rise.
  task automatic waitRvalid(input string tag);
    for (int i = 0; i < 8 && !rvalid; i++) tick();
    checkOutput(tag, 256'(rvalid), 256'd1);
  endtask

  logic [255:0] exp_beat [4];
  logic [255:0] strobe_exp;
  logic [3:0]   rr_pat;
  int           beats;
  int           cyc;

  initial begin
    rst_n   = 1'b0;
    awid    = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata   = '0; wstrb  = '0; wlast = 1'b0; wvalid = 1'b0;
    bready  = 1'b0;
    arid    = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready  = 1'b0;

    // Preload before reset; the contents must survive reset.
    #2;
    dut.mem[0] = 256'hDEADBEEF;
    dut.mem[1] = 256'h1111_2222;

    // Reset values.
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_awready", 256'(awready), 256'd1);
    checkOutput("rst_arready", 256'(arready), 256'd1);
    checkOutput("rst_wready",  256'(wready),  256'd0);
    checkOutput("rst_bvalid",  256'(bvalid),  256'd0);
    checkOutput("rst_rvalid",  256'(rvalid),  256'd0);
    checkOutput("rst_rlast",   256'(rlast),   256'd0);
    checkOutput("rst_rdata",   rdata,         256'd0);
    checkOutput("rst_mem0",    dut.mem[0],    256'hDEADBEEF);
    rst_n = 1'b0;
    tick();

    // Single-beat read: rvalid exactly 2 edges after the AR handshake.
    $display("[TB] single-beat read");
    sendAr(40'h0, 8'd0, 2'b01, 4'd3);
    checkOutput("rd1_lat_k",  256'(rvalid), 256'd0);
    tick();
    checkOutput("rd1_lat_k1", 256'(rvalid), 256'd0);
    tick();
    checkOutput("rd1_rvalid", 256'(rvalid), 256'd1);
    checkOutput("rd1_rdata",  rdata,        256'hDEADBEEF);
    checkOutput("rd1_rlast",  256'(rlast),  256'd1);
    checkOutput("rd1_rid",    256'(rid),    256'd3);
    checkOutput("rd1_rresp",  256'(rresp),  256'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput("rd1_done_rvalid",  256'(rvalid),  256'd0);
    checkOutput("rd1_done_arready", 256'(arready), 256'd1);

    // INCR write burst of 4 beats to 0x40 -> words 2..5.
    $display("[TB] INCR write burst");
    sendAw(40'h40, 8'd3, 2'b01, 4'd5);
    checkOutput("wr_awready_low", 256'(awready), 256'd0);
    checkOutput("wr_wready",      256'(wready),  256'd1);
    applyStimulus(256'd1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(256'd2, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(256'd3, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(256'd4, 32'hFFFF_FFFF, 1'b1);
    checkOutput("wr_bvalid_early", 256'(bvalid), 256'd0);
    tick();
    checkOutput("wr_bvalid", 256'(bvalid), 256'd1);
    checkOutput("wr_bresp",  256'(bresp),  256'd0);
    checkOutput("wr_bid",    256'(bid),    256'd5);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("wr_bvalid_done", 256'(bvalid),  256'd0);
    checkOutput("wr_awready_back", 256'(awready), 256'd1);
    checkOutput("wr_mem2", dut.mem[2], 256'd1);
    checkOutput("wr_mem3", dut.mem[3], 256'd2);
    checkOutput("wr_mem4", dut.mem[4], 256'd3);
    checkOutput("wr_mem5", dut.mem[5], 256'd4);

    // Byte strobes: only the low 4 bytes of word 7 are cleared.
    $display("[TB] byte strobes");
    dut.mem[7] = {256{1'b1}};
    sendAw(40'hE0, 8'd0, 2'b01, 4'd9);
    applyStimulus(256'd0, 32'h0000_000F, 1'b1);
    finishWrite("strb", 4'd9);
    strobe_exp = {{224{1'b1}}, 32'h0};
    checkOutput("strb_mem7", dut.mem[7], strobe_exp);

    // Read backpressure: 4 beats from 0 with rready cycling 1,0,0,1.
    $display("[TB] read backpressure");
    exp_beat[0] = 256'hDEADBEEF;
    exp_beat[1] = 256'h1111_2222;
    exp_beat[2] = 256'd1;
    exp_beat[3] = 256'd2;
    rr_pat = 4'b1001;
    sendAr(40'h0, 8'd3, 2'b01, 4'd4);
    waitRvalid("bp_first_rvalid");
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 40) begin
      rready = rr_pat[3 - (cyc % 4)];
      if (rvalid) begin
        checkOutput($sformatf("bp_rdata_b%0d_c%0d", beats, cyc), rdata, exp_beat[beats]);
        checkOutput($sformatf("bp_rlast_b%0d_c%0d", beats, cyc), 256'(rlast),
                    256'(beats == 3));
        if (rready) beats++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    checkOutput("bp_beats",       256'(beats),  256'd4);
    checkOutput("bp_rvalid_done", 256'(rvalid), 256'd0);

    // FIXED write: both beats land on word 1, the second one wins.
    $display("[TB] FIXED write");
    sendAw(40'h20, 8'd1, 2'b00, 4'd6);
    applyStimulus(256'hAAAA, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(256'hBBBB, 32'hFFFF_FFFF, 1'b1);
    finishWrite("fixed", 4'd6);
    checkOutput("fixed_mem1", dut.mem[1], 256'hBBBB);
    checkOutput("fixed_mem2", dut.mem[2], 256'd1);

    // Address wrap: byte address 1 MiB aliases to word 0.
    $display("[TB] address wrap");
    sendAr(40'h10_0000, 8'd0, 2'b01, 4'd2);
    waitRvalid("wrap_rvalid");
    checkOutput("wrap_rdata", rdata,       256'hDEADBEEF);
    checkOutput("wrap_rid",   256'(rid),   256'd2);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Reset during the second beat of a 4-beat read from 0x40.
    $display("[TB] reset mid-burst");
    sendAr(40'h40, 8'd3, 2'b01, 4'd7);
    waitRvalid("mid_rvalid");
    checkOutput("mid_beat0", rdata, 256'd1);
    rready = 1'b1;
    tick();
    checkOutput("mid_beat1", rdata, 256'd2);
    rst_n = 1'b1;
    tick();
    rst_n  = 1'b0;
    rready = 1'b0;
    checkOutput("mid_rvalid_off", 256'(rvalid),  256'd0);
    checkOutput("mid_arready",    256'(arready), 256'd1);
    checkOutput("mid_rdata_clr",  rdata,         256'd0);
    checkOutput("mid_mem2", dut.mem[2], 256'd1);
    checkOutput("mid_mem5", dut.mem[5], 256'd4);
    checkOutput("mid_mem0", dut.mem[0], 256'hDEADBEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
